// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter sharing one AXI-Stream sink between NUM_PORTS sources.
// Define AXIS_RR_ARBITER_PACKET_LOCK_EN to hold each grant for a whole packet.
module axis_rr_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned IDX_WIDTH  = 2,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_PORTS-1:0]            s_valid,
  input  logic [NUM_PORTS-1:0]            s_last,
  output logic [NUM_PORTS-1:0]            s_ready,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic                            m_valid,
  output logic                            m_last,
  input  logic                            m_ready,
  output logic [IDX_WIDTH-1:0]            grant_index,
  output logic                            busy
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   grant_q, grant_d;
  logic [IDX_WIDTH-1:0]   ptr_q, ptr_d;
  logic [IDX_WIDTH-1:0]   ptr_next;

`ifndef AXIS_RR_ARBITER_PACKET_LOCK_EN
  localparam int unsigned CNT_WIDTH = $clog2(MAX_BURST + 1);
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
`endif

  logic                   found_hi, found_lo;
  logic [IDX_WIDTH-1:0]   idx_hi, idx_lo;
  logic                   sel_found;
  logic [IDX_WIDTH-1:0]   sel_idx;

  logic [DATA_WIDTH-1:0]  g_data;
  logic                   g_valid;
  logic                   g_last;
  logic                   accept;
  logic                   release_grant;

  // Rotating priority: first requester at or above the pointer, else wrap to the lowest.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (s_valid[i] && !found_lo) begin
        found_lo = 1'b1;
        idx_lo   = IDX_WIDTH'(i);
      end
      if (s_valid[i] && !found_hi && (IDX_WIDTH'(i) >= ptr_q)) begin
        found_hi = 1'b1;
        idx_hi   = IDX_WIDTH'(i);
      end
    end
    sel_found = found_lo;
    sel_idx   = found_hi ? idx_hi : idx_lo;
  end

  // Select the granted source's stream signals.
  always_comb begin
    g_data  = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == IDX_WIDTH'(i)) begin
        g_data  = s_data[i*DATA_WIDTH +: DATA_WIDTH];
        g_valid = s_valid[i];
        g_last  = s_last[i];
      end
    end
  end

  assign ptr_next = (grant_q == IDX_WIDTH'(NUM_PORTS - 1)) ? '0 : grant_q + IDX_WIDTH'(1);

  // Next-state and stream outputs; nothing is offered to either side while reset is asserted.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    ptr_d         = ptr_q;
`ifndef AXIS_RR_ARBITER_PACKET_LOCK_EN
    cnt_d         = cnt_q;
`endif
    m_data        = g_data;
    m_valid       = 1'b0;
    m_last        = 1'b0;
    s_ready       = '0;
    accept        = 1'b0;
    release_grant = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          grant_d = sel_idx;
          state_d = ST_GRANT;
`ifndef AXIS_RR_ARBITER_PACKET_LOCK_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (aresetn) begin
          m_valid = g_valid;
          m_last  = g_last;
          for (int i = 0; i < NUM_PORTS; i++) begin
            s_ready[i] = (grant_q == IDX_WIDTH'(i)) && m_ready;
          end
        end
        accept = g_valid && m_ready;
`ifdef AXIS_RR_ARBITER_PACKET_LOCK_EN
        release_grant = accept && g_last;
`else
        if (!g_valid) begin
          release_grant = 1'b1;
        end else if (accept) begin
          if (cnt_q == CNT_WIDTH'(MAX_BURST - 1)) begin
            release_grant = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
`endif
        if (release_grant) begin
          state_d = ST_IDLE;
          ptr_d   = ptr_next;
`ifndef AXIS_RR_ARBITER_PACKET_LOCK_EN
          cnt_d   = '0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
`ifndef AXIS_RR_ARBITER_PACKET_LOCK_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
`ifndef AXIS_RR_ARBITER_PACKET_LOCK_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign grant_index = grant_q;
  assign busy        = (state_q == ST_GRANT);

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter against a transaction-level arbitration model.
// Honours AXIS_RR_ARBITER_PACKET_LOCK_EN when defined for both DUT and bench.
module tb_axis_rr_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned NP = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned MB = 4;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [NP*DW-1:0]  s_data;
  logic [NP-1:0]     s_valid;
  logic [NP-1:0]     s_last;
  logic [NP-1:0]     s_ready;
  logic [DW-1:0]     m_data;
  logic              m_valid;
  logic              m_last;
  logic              m_ready;
  logic [IW-1:0]     grant_index;
  logic              busy;

  axis_rr_arbiter #(
    .DATA_WIDTH(DW), .NUM_PORTS(NP), .IDX_WIDTH(IW), .MAX_BURST(MB)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .grant_index(grant_index), .busy(busy)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int fails  = 0;

  // Arbitration model: who holds the grant, where the search starts, beats taken so far.
  bit   mdl_busy;
  int   mdl_g, mdl_ptr, mdl_cnt;
  int   seq[NP];
  int   pkt_len[NP];
  logic [7:0] salt[NP];

  logic              exp_mvalid, exp_mlast, exp_busy;
  logic [DW-1:0]     exp_mdata;
  logic [NP-1:0]     exp_sready;
  logic [IW-1:0]     exp_gidx;
  logic [NP+IW+2:0]  ctl_exp;
  logic [NP+IW+2:0]  ctl_dut;

  assign ctl_dut = {m_valid, m_last, s_ready, busy, grant_index};

  function automatic logic [DW-1:0] beat_data(int i);
    return {salt[i], 24'(seq[i])};
  endfunction

  function automatic logic beat_last(int i);
    return (pkt_len[i] != 0) && ((seq[i] % pkt_len[i]) == pkt_len[i] - 1);
  endfunction

  task automatic drive_data();
    for (int i = 0; i < NP; i++) begin
      s_data[i*DW +: DW] = beat_data(i);
      s_last[i]          = beat_last(i);
    end
  endtask

  task automatic model_outputs();
    exp_mvalid = 1'b0;
    exp_mlast  = 1'b0;
    exp_sready = '0;
    exp_mdata  = '0;
    exp_busy   = mdl_busy;
    exp_gidx   = IW'(mdl_g);
    if (mdl_busy && aresetn) begin
      exp_mvalid        = s_valid[mdl_g];
      exp_mlast         = s_last[mdl_g];
      exp_mdata         = beat_data(mdl_g);
      exp_sready[mdl_g] = m_ready;
    end
    ctl_exp = {exp_mvalid, exp_mlast, exp_sready, exp_busy, exp_gidx};
  endtask

  task automatic model_advance();
    bit acc, was_last, rel, found;
    rel = 1'b0;
    if (!aresetn) begin
      mdl_busy = 1'b0; mdl_ptr = 0; mdl_cnt = 0; mdl_g = 0;
      for (int i = 0; i < NP; i++) seq[i] = 0;
    end else if (!mdl_busy) begin
      found = 1'b0;
      for (int k = 0; k < NP; k++) begin
        if (!found && s_valid[(mdl_ptr + k) % NP]) begin
          found = 1'b1; mdl_busy = 1'b1; mdl_g = (mdl_ptr + k) % NP; mdl_cnt = 0;
        end
      end
    end else begin
      acc      = s_valid[mdl_g] && m_ready;
      was_last = beat_last(mdl_g);
      if (acc) seq[mdl_g]++;
`ifdef AXIS_RR_ARBITER_PACKET_LOCK_EN
      rel = acc && was_last;
`else
      if (!s_valid[mdl_g]) rel = 1'b1;
      else if (acc) begin
        mdl_cnt++;
        if (mdl_cnt == MB) rel = 1'b1;
      end
`endif
      if (rel) begin
        mdl_busy = 1'b0; mdl_ptr = (mdl_g + 1) % NP; mdl_cnt = 0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge aclk);
    model_advance();
    #1;
    drive_data();
  endtask

  task automatic apply_reset();
    aresetn = 1'b0;
    s_valid = '0;
    m_ready = 1'b1;
    for (int i = 0; i < NP; i++) begin
      pkt_len[i] = 8;
      salt[i]    = 8'(i * 16 + int'($urandom_range(0, 15)));
    end
    cycle();
    cycle();
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    aresetn = 1'b0;
    for (int c = 0; c < 3; c++) begin
      s_valid = NP'($urandom);
      @(negedge aclk);
      model_outputs();
      checks++;
      if (ctl_dut !== ctl_exp || busy !== 1'b0 || grant_index !== '0) begin
        fails++;
        $display("FAIL reset_state cyc=%0d got %b want %b", c, ctl_dut, ctl_exp);
      end
      cycle();
    end
    aresetn = 1'b1;
    s_valid = '0;
    cycle();
  endtask

  task automatic test_single();
    int hs = 0;
    int want;
    apply_reset();
    s_valid = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      @(negedge aclk);
      model_outputs();
      if (s_valid[2] && s_ready[2]) hs++;
      checks++;
      if (ctl_dut !== ctl_exp) begin
        fails++;
        $display("FAIL single_ctl cyc=%0d got %b want %b", c, ctl_dut, ctl_exp);
      end
      if (exp_mvalid) begin
        checks++;
        if (m_data !== exp_mdata) begin
          fails++;
          $display("FAIL single_data cyc=%0d got %h want %h", c, m_data, exp_mdata);
        end
      end
      cycle();
    end
`ifdef AXIS_RR_ARBITER_PACKET_LOCK_EN
    want = 17;
`else
    want = 16;
`endif
    checks++;
    if (hs != want) begin
      fails++;
      $display("FAIL single_beats got %0d want %0d", hs, want);
    end
  endtask

  task automatic test_all_rr();
    int order[$];
    int want[5] = '{0, 1, 2, 3, 0};
    logic prev_busy = 1'b0;
    apply_reset();
    s_valid = '1;
    for (int c = 0; c < 45; c++) begin
      @(negedge aclk);
      model_outputs();
      if (busy && !prev_busy) order.push_back(int'(grant_index));
      prev_busy = busy;
      checks++;
      if (ctl_dut !== ctl_exp) begin
        fails++;
        $display("FAIL rr_ctl cyc=%0d got %b want %b", c, ctl_dut, ctl_exp);
      end
      if (exp_mvalid) begin
        checks++;
        if (m_data !== exp_mdata) begin
          fails++;
          $display("FAIL rr_data cyc=%0d got %h want %h", c, m_data, exp_mdata);
        end
      end
      cycle();
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (k >= order.size()) begin
        fails++;
        $display("FAIL rr_order idx=%0d got none want %0d", k, want[k]);
      end else if (order[k] != want[k]) begin
        fails++;
        $display("FAIL rr_order idx=%0d got %0d want %0d", k, order[k], want[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int hs = 0;
    logic rdy[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    apply_reset();
    s_valid = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      m_ready = rdy[c];
      @(negedge aclk);
      model_outputs();
      if (c > 0 && s_valid[1] && s_ready[1]) hs++;
      checks++;
      if (ctl_dut !== ctl_exp) begin
        fails++;
        $display("FAIL bp_ctl cyc=%0d got %b want %b", c, ctl_dut, ctl_exp);
      end
      if (exp_mvalid) begin
        checks++;
        if (m_data !== exp_mdata) begin
          fails++;
          $display("FAIL bp_data cyc=%0d got %h want %h", c, m_data, exp_mdata);
        end
      end
      cycle();
    end
    checks++;
    if (hs != 2) begin
      fails++;
      $display("FAIL bp_beats got %0d want 2", hs);
    end
    m_ready = 1'b1;
  endtask

`ifndef AXIS_RR_ARBITER_PACKET_LOCK_EN
  task automatic test_gap();
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      s_valid = {1'b1, 2'b00, (c < 4)};
      @(negedge aclk);
      model_outputs();
      checks++;
      if (ctl_dut !== ctl_exp) begin
        fails++;
        $display("FAIL gap_ctl cyc=%0d got %b want %b", c, ctl_dut, ctl_exp);
      end
      if (c == 5) begin
        checks++;
        if (busy !== 1'b0) begin
          fails++;
          $display("FAIL gap_idle got busy=%b want 0", busy);
        end
      end
      if (c == 6) begin
        checks++;
        if ({busy, grant_index} !== {1'b1, IW'(3)}) begin
          fails++;
          $display("FAIL gap_regrant got busy=%b g=%0d want busy=1 g=3", busy, grant_index);
        end
      end
      cycle();
    end
  endtask
`else
  task automatic test_packet_lock();
    int hs = 0, gap = 0, last_cyc = -1, first0 = -1, stray = 0;
    apply_reset();
    pkt_len[2] = 40;
    drive_data();
    for (int c = 0; c < 70; c++) begin
      s_valid[2] = (seq[2] < 40);
      if (seq[2] == 10 && gap < 2) begin
        s_valid[2] = 1'b0;
        gap++;
      end
      s_valid[0] = (c >= 2);
      @(negedge aclk);
      model_outputs();
      if (s_valid[2] && s_ready[2]) begin
        hs++;
        if (s_last[2]) last_cyc = c;
      end
      if (busy && last_cyc < 0 && grant_index != IW'(2)) stray++;
      if (busy && grant_index == IW'(0) && first0 < 0) first0 = c;
      checks++;
      if (ctl_dut !== ctl_exp) begin
        fails++;
        $display("FAIL lock_ctl cyc=%0d got %b want %b", c, ctl_dut, ctl_exp);
      end
      cycle();
    end
    checks++;
    if (hs != 40 || stray != 0 || last_cyc < 0 || first0 - last_cyc != 2) begin
      fails++;
      $display("FAIL lock_packet got beats=%0d stray=%0d last=%0d grant0=%0d want 40/0/gap 2",
               hs, stray, last_cyc, first0);
    end
  endtask
`endif

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < NP; i++) pkt_len[i] = int'($urandom_range(1, 6));
    drive_data();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NP; i++) s_valid[i] = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      @(negedge aclk);
      model_outputs();
      checks++;
      if (ctl_dut !== ctl_exp) begin
        fails++;
        $display("FAIL rand_ctl cyc=%0d got %b want %b", c, ctl_dut, ctl_exp);
      end
      if (exp_mvalid) begin
        checks++;
        if (m_data !== exp_mdata) begin
          fails++;
          $display("FAIL rand_data cyc=%0d got %h want %h", c, m_data, exp_mdata);
        end
      end
      cycle();
    end
    m_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    s_valid = 4'b0010;
    for (int c = 0; c < 6; c++) begin
      aresetn = (c != 3);
      @(negedge aclk);
      model_outputs();
      checks++;
      if (ctl_dut !== ctl_exp) begin
        fails++;
        $display("FAIL rstmid_ctl cyc=%0d got %b want %b", c, ctl_dut, ctl_exp);
      end
      if (c == 4) begin
        checks++;
        if ({busy, m_valid, s_ready, grant_index} !== '0) begin
          fails++;
          $display("FAIL rstmid_drop got busy=%b v=%b rdy=%b g=%0d want all 0",
                   busy, m_valid, s_ready, grant_index);
        end
      end
      if (c == 5) begin
        checks++;
        if ({busy, grant_index} !== {1'b1, IW'(1)}) begin
          fails++;
          $display("FAIL rstmid_regrant got busy=%b g=%0d want busy=1 g=1", busy, grant_index);
        end
      end
      cycle();
    end
  endtask

  initial begin
    aresetn = 1'b0;
    s_valid = '0;
    m_ready = 1'b1;
    mdl_busy = 1'b0; mdl_g = 0; mdl_ptr = 0; mdl_cnt = 0;
    for (int i = 0; i < NP; i++) begin
      seq[i] = 0; pkt_len[i] = 8; salt[i] = 8'(i);
    end
    drive_data();
    test_reset();
    test_single();
    test_all_rr();
    test_backpressure();
`ifndef AXIS_RR_ARBITER_PACKET_LOCK_EN
    test_gap();
`else
    test_packet_lock();
`endif
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- Round-robin arbiter that shares one AXI-Stream sink between NUM_PORTS AXI-Stream sources.
- A typical sink is a single skid/input buffer feeding a DMA writer or FIFO.
- The grant is registered and the data path is a combinational mux from the granted source.
- Arbitration is burst-based: a grant holds for a bounded number of beats, or for a whole packet in lock mode.

Parameters:
- DATA_WIDTH, 32: width of one stream's data.
- NUM_PORTS, 4: number of requesters, 2..16.
- IDX_WIDTH, 2: width of grant index; must satisfy 2**IDX_WIDTH >= NUM_PORTS.
- MAX_BURST, 16: beats accepted per grant before forced release, 1..65535.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low; clock aclk.
- s_data  in  NUM_PORTS*DATA_WIDTH  source data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_valid  in  NUM_PORTS  per-source valid.
- s_last  in  NUM_PORTS  per-source end-of-packet.
- s_ready  out  NUM_PORTS  per-source ready.
- m_data  out  DATA_WIDTH  granted source's data.
- m_valid  out  1  granted source's valid.
- m_last  out  1  granted source's last.
- m_ready  in  1  sink ready.
- grant_index  out  IDX_WIDTH  index of current or most recent grant.
- busy  out  1  high while in GRANT.

Behaviour:
- Reset values: state IDLE; pointer=0; beat counter=0; grant_index=0; busy=0.
- Reset outputs: m_valid=0, s_ready=0, m_last=0. m_data is don't-care.
- Reset mid-burst: the grant is dropped immediately on the next edge. No beat is accepted in the reset cycle.
- IDLE:
  - m_valid=0, all s_ready=0, m_last=0.
  - If any s_valid is high, select the first i with s_valid[i]=1, searching pointer, pointer+1, ... modulo NUM_PORTS.
  - On that cycle's edge: grant_index<=i, counter<=0, state<=GRANT.
  - If no request, stay in IDLE.
- GRANT (g=grant_index):
  - m_data=s_data[g], m_valid=s_valid[g], m_last=s_last[g].
  - s_ready[g]=m_ready; all other s_ready=0.
  - A beat is accepted when s_valid[g] & m_ready. Each accepted beat increments the counter.
  - Release condition, default mode: either
    - an accepted beat while counter==MAX_BURST-1, or
    - s_valid[g]=0 during any GRANT cycle.
  - On release: state<=IDLE, pointer<=(g+1) mod NUM_PORTS, counter<=0. grant_index keeps g.
  - Release when s_valid[g]=0: no beat is transferred that cycle.
- Latency and throughput:
  - First beat is presented one cycle after a request is seen in IDLE.
  - Every release inserts exactly one IDLE cycle; there is no back-to-back grant.
  - Peak throughput is MAX_BURST beats per MAX_BURST+1 cycles per grant.
- Requesters ignored by the search are not starved: the pointer advances past each granted port.
- m_ready low holds the beat; the counter is unchanged and the grant is not released.
- Simultaneous requests from all ports are granted in order pointer, pointer+1, ...
- MAX_BURST=1: every accepted beat releases the grant.
- Counter width is ceil(log2(MAX_BURST+1)) bits and never wraps, because release occurs at MAX_BURST-1.
- busy=1 exactly in GRANT.

Optional Feature:
- Macro AXIS_RR_ARBITER_PACKET_LOCK_EN.
- When defined, the grant is held for a whole packet:
  - Release occurs only on an accepted beat with s_last[g]=1.
  - s_valid[g]=0 does not release the grant; the arbiter waits.
  - MAX_BURST is ignored and the counter is not implemented.
- When undefined, the default-mode release rules apply and s_last is passed through only.

Test Plan:
- Reset then single requester: s_valid=4'b0100, m_ready=1, 20 beats.
  - Grant 2 one cycle after request. Release after 16 beats, 1 IDLE cycle, then re-grant 2 for the remaining 4 beats.
  - grant_index=2 throughout.
- All four request continuously, m_ready=1, MAX_BURST=4.
  - Grant order 0,1,2,3,0.
  - Each grant carries 4 beats followed by 1 idle cycle (m_valid=0).
- Backpressure: port 1 granted, m_ready toggles 1,0,1,0.
  - s_ready[1] tracks m_ready. Counter advances only on accepted beats, so 4 toggle cycles yield 2 accepted beats.
  - m_data is stable while m_ready=0.
- Gap release (default mode): port 0 valid for 3 beats then low for 1 cycle while port 3 requests.
  - Release in the gap cycle, IDLE for 1 cycle, then grant 3.
- Packet lock (macro defined): port 2 sends 40 beats with s_last on beat 40 and a 2-cycle valid gap at beat 10; port 0 also requests.
  - Grant stays on 2 through all 40 beats. Port 0 is granted 2 cycles after the last beat.
- Reset mid-burst: assert aresetn=0 during beat 3 of port 1.
  - Next cycle: busy=0, m_valid=0, s_ready=0, pointer=0, grant_index=0.
  - After release of reset with port 1 requesting, grant_index=1 on the next edge.
